// File: rtl/fpu_issue_pkg.sv
// Shared types for the FPU issue/writeback controller: FPU request layout,
// slot bookkeeping and the queue entry that pairs a request with its rd.
package fpu_issue_pkg;

    localparam int unsigned STATUS_W = 5;
    localparam int unsigned RD_W     = 5;
    localparam int unsigned DATA_W   = 64;

    // Encodings follow the fpnew_pkg enums so the request drops straight onto the FPU.
    typedef enum logic [2:0] {
        RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010, RUP = 3'b011,
        RMM = 3'b100, DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD = 4'd0, FNMSUB = 4'd1, ADD = 4'd2, MUL = 4'd3, DIV = 4'd4,
        SQRT = 4'd5, SGNJ = 4'd6, MINMAX = 4'd7, CMP = 4'd8, CLASSIFY = 4'd9,
        F2F = 4'd10, F2I = 4'd11, I2F = 4'd12, CPKAB = 4'd13, CPKCD = 4'd14
    } operation_e;

    typedef enum logic [2:0] {
        FP32 = 3'd0, FP64 = 3'd1, FP16 = 3'd2, FP8 = 3'd3, FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic [1:0] {
        INT8 = 2'd0, INT16 = 2'd1, INT32 = 2'd2, INT64 = 2'd3
    } int_format_e;

    typedef struct packed {
        logic [2:0][DATA_W-1:0] operands;
        roundmode_e             rnd_mode;
        operation_e             op;
        logic                   op_mod;
        fp_format_e             src_fmt;
        fp_format_e             dst_fmt;
        int_format_e            int_fmt;
        logic                   vectorial_op;
    } fpu_req_t;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
    } slot_t;

    typedef struct packed {
        fpu_req_t        req;
        logic [RD_W-1:0] rd;
    } queue_entry_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: 5'd0};

    // Sticky flag update: an optional clear happens first, then the accumulate.
    function automatic logic [STATUS_W-1:0] merge_fflags(
        input logic [STATUS_W-1:0] cur,
        input logic [STATUS_W-1:0] status,
        input logic                clr,
        input logic                acc
    );
        logic [STATUS_W-1:0] base;
        base = clr ? {STATUS_W{1'b0}} : cur;
        return acc ? (base | status) : base;
    endfunction

endpackage

// File: rtl/fpu_issue_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers and a synchronous flush.
module fpu_issue_fifo #(
    parameter type         T     = logic,
    parameter int unsigned Depth = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  T     wdata,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(Depth);

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    T            mem_r [Depth];

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign rdata = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; the extra top bit distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push && !full) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop && !empty) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push && !full && !rst && !flush) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue/writeback controller between the FP decode stage and a pipelined FPU:
// queues requests, tags issues with free slots, matches results to rd.
module fpu_issue_ctrl
    import fpu_issue_pkg::*;
#(
    parameter int unsigned QueueDepth = 4,
    parameter int unsigned TagWidth   = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  fpu_req_t            req_i,
    input  logic [RD_W-1:0]     req_rd_i,
    output logic                fpu_valid_o,
    input  logic                fpu_ready_i,
    output fpu_req_t            fpu_req_o,
    output logic [TagWidth-1:0] fpu_tag_o,
    output logic                fpu_flush_o,
    input  logic                fpu_valid_i,
    output logic                fpu_ready_o,
    input  logic [DATA_W-1:0]   fpu_result_i,
    input  logic [STATUS_W-1:0] fpu_status_i,
    input  logic [TagWidth-1:0] fpu_tag_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [RD_W-1:0]     wb_rd_o,
    output logic [DATA_W-1:0]   wb_data_o,
    output logic [STATUS_W-1:0] fflags_o,
    input  logic                fflags_clr_i,
    input  logic                flush_i,
    output logic                busy_o
);

    localparam int NumSlots = 1 << TagWidth;

    queue_entry_t        push_entry_s;
    queue_entry_t        head_s;
    logic                q_full_s;
    logic                q_empty_s;
    logic                push_s;
    logic                issue_s;
    logic                res_acc_s;
    logic                res_hit_s;
    logic                free_found_s;
    logic [TagWidth-1:0] free_tag_s;
    logic                waw_s;
    logic                any_slot_s;
    logic [TagWidth-1:0] issue_tag_s;

    slot_t               slots_r [NumSlots];
    logic                lock_valid_r;
    logic [TagWidth-1:0] lock_tag_r;
    logic                wb_valid_r;
    logic [RD_W-1:0]     wb_rd_r;
    logic [DATA_W-1:0]   wb_data_r;
    logic [STATUS_W-1:0] fflags_r;

    assign push_entry_s = '{req: req_i, rd: req_rd_i};

    fpu_issue_fifo #(
        .T     (queue_entry_t),
        .Depth (QueueDepth)
    ) u_queue (
        .clk   (clk_i),
        .rst   (rst_i),
        .flush (flush_i),
        .push  (push_s),
        .pop   (issue_s),
        .wdata (push_entry_s),
        .rdata (head_s),
        .full  (q_full_s),
        .empty (q_empty_s)
    );

    // Slot scan: lowest free index, WAW hazard against the head rd, occupancy.
    always_comb begin
        free_found_s = 1'b0;
        free_tag_s   = {TagWidth{1'b0}};
        waw_s        = 1'b0;
        any_slot_s   = 1'b0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!slots_r[i].valid) begin
                free_found_s = 1'b1;
                free_tag_s   = TagWidth'(i);
            end else begin
                any_slot_s = 1'b1;
                waw_s      = waw_s | (slots_r[i].rd == head_s.rd);
            end
        end
    end

    // A locked tag is always still free: slots only get freed while an issue waits.
    assign issue_tag_s = lock_valid_r ? lock_tag_r : free_tag_s;

    assign req_ready_o = !rst_i && !q_full_s && !flush_i;
    assign push_s      = req_valid_i && req_ready_o;
    assign fpu_valid_o = !rst_i && !q_empty_s && free_found_s && !waw_s && !flush_i;
    assign issue_s     = fpu_valid_o && fpu_ready_i;
    assign fpu_req_o   = head_s.req;
    assign fpu_tag_o   = issue_tag_s;
    assign fpu_flush_o = flush_i && !rst_i;

    assign fpu_ready_o = !wb_valid_r || wb_ready_i;
    assign res_acc_s   = fpu_valid_i && fpu_ready_o && !flush_i && !rst_i;
    assign res_hit_s   = res_acc_s && slots_r[fpu_tag_i].valid;

    assign wb_valid_o = wb_valid_r;
    assign wb_rd_o    = wb_rd_r;
    assign wb_data_o  = wb_data_r;
    assign fflags_o   = fflags_r;
    assign busy_o     = !rst_i && (!q_empty_s || any_slot_s || wb_valid_r);

    // Tag lock keeps fpu_tag_o stable while the FPU back-pressures an offered issue.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            lock_valid_r <= 1'b0;
            lock_tag_r   <= {TagWidth{1'b0}};
        end else begin
            lock_valid_r <= fpu_valid_o && !fpu_ready_i;
            lock_tag_r   <= issue_tag_s;
        end
    end

    // Slot table: free on matched result first, then allocate on issue.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            for (int i = 0; i < NumSlots; i++) begin
                slots_r[i] <= SLOT_EMPTY;
            end
        end else begin
            if (res_hit_s) begin
                slots_r[fpu_tag_i].valid <= 1'b0;
            end
            if (issue_s) begin
                slots_r[issue_tag_s] <= '{valid: 1'b1, rd: head_s.rd};
            end
        end
    end

    // Single-entry writeback register; reloads in the same cycle it drains.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wb_valid_r <= 1'b0;
            wb_rd_r    <= {RD_W{1'b0}};
            wb_data_r  <= {DATA_W{1'b0}};
        end else if (res_hit_s) begin
            wb_valid_r <= 1'b1;
            wb_rd_r    <= slots_r[fpu_tag_i].rd;
            wb_data_r  <= fpu_result_i;
        end else if (wb_ready_i) begin
            wb_valid_r <= 1'b0;
        end
    end

    // Sticky status flags survive a flush; only reset or an explicit clear drops them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fflags_r <= {STATUS_W{1'b0}};
        end else begin
            fflags_r <= merge_fflags(fflags_r, fpu_status_i, fflags_clr_i, res_hit_s);
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: inputs change on the falling edge, outputs
// are checked 1 time unit later, writebacks are matched against a queue.
module tb_fpu_issue_ctrl;
    import fpu_issue_pkg::*;

    logic        clk;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    fpu_req_t    req_i;
    logic [4:0]  req_rd_i;
    logic        fpu_valid_o;
    logic        fpu_ready_i;
    fpu_req_t    fpu_req_o;
    logic [0:0]  fpu_tag_o;
    logic        fpu_flush_o;
    logic        fpu_valid_i;
    logic        fpu_ready_o;
    logic [63:0] fpu_result_i;
    logic [4:0]  fpu_status_i;
    logic [0:0]  fpu_tag_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [4:0]  wb_rd_o;
    logic [63:0] wb_data_o;
    logic [4:0]  fflags_o;
    logic        fflags_clr_i;
    logic        flush_i;
    logic        busy_o;

    int vectors     = 0;
    int miscompares = 0;
    logic [68:0] sb [$];

    fpu_issue_ctrl #(.QueueDepth(4), .TagWidth(1)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_i(req_i), .req_rd_i(req_rd_i),
        .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i),
        .fpu_req_o(fpu_req_o), .fpu_tag_o(fpu_tag_o), .fpu_flush_o(fpu_flush_o),
        .fpu_valid_i(fpu_valid_i), .fpu_ready_o(fpu_ready_o),
        .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
        .flush_i(flush_i), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wb(input string tag);
        logic [68:0] e;
        check({tag, "_valid"}, 256'(wb_valid_o), 256'(1'b1));
        vectors++;
        assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_rd"}, 256'(wb_rd_o), 256'(e[68:64]));
            check({tag, "_data"}, 256'(wb_data_o), 256'(e[63:0]));
        end
    endtask

    function automatic fpu_req_t mk_req(input operation_e op, input logic [63:0] seed);
        fpu_req_t r;
        r.operands[0]  = seed;
        r.operands[1]  = ~seed;
        r.operands[2]  = seed ^ 64'hA5A5_5A5A_0F0F_F0F0;
        r.rnd_mode     = RNE;
        r.op           = op;
        r.op_mod       = 1'b0;
        r.src_fmt      = FP64;
        r.dst_fmt      = FP64;
        r.int_fmt      = INT64;
        r.vectorial_op = 1'b0;
        return r;
    endfunction

    task automatic push_req(input fpu_req_t r, input logic [4:0] rd);
        req_valid_i = 1'b1;
        req_i       = r;
        req_rd_i    = rd;
    endtask

    task automatic give_result(input logic [0:0] tag, input logic [63:0] d, input logic [4:0] st);
        fpu_valid_i  = 1'b1;
        fpu_tag_i    = tag;
        fpu_result_i = d;
        fpu_status_i = st;
    endtask

    initial begin
        // reset, with flush and a push request held high to prove both are ignored
        rst_i = 1'b1; flush_i = 1'b1; fflags_clr_i = 1'b0;
        push_req(mk_req(ADD, 64'h1), 5'd31);
        fpu_ready_i = 1'b1; wb_ready_i = 1'b1;
        fpu_valid_i = 1'b0; fpu_tag_i = 1'b0; fpu_result_i = 64'h0; fpu_status_i = 5'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_fpu_valid", 256'(fpu_valid_o), 256'(1'b0));
        check("rst_wb_valid", 256'(wb_valid_o), 256'(1'b0));
        check("rst_fflags", 256'(fflags_o), 256'(5'd0));
        check("rst_busy", 256'(busy_o), 256'(1'b0));
        check("rst_flush_o", 256'(fpu_flush_o), 256'(1'b0));
        @(negedge clk); rst_i = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; #1;
        check("post_rst_ready", 256'(req_ready_o), 256'(1'b1));
        check("post_rst_fpu_valid", 256'(fpu_valid_o), 256'(1'b0));
        check("post_rst_busy", 256'(busy_o), 256'(1'b0));
        check("post_rst_wb_valid", 256'(wb_valid_o), 256'(1'b0));

        // single op
        @(negedge clk); push_req(mk_req(ADD, 64'h3), 5'd3); #1;
        check("t1_no_bypass", 256'(fpu_valid_o), 256'(1'b0));
        @(negedge clk); req_valid_i = 1'b0; #1;
        check("t1_issue_valid", 256'(fpu_valid_o), 256'(1'b1));
        check("t1_tag", 256'(fpu_tag_o), 256'(1'b0));
        check("t1_req", 256'(fpu_req_o), 256'(mk_req(ADD, 64'h3)));
        @(negedge clk); give_result(1'b0, 64'h4000_0000_0000_0000, 5'b00001);
        sb.push_back({5'd3, 64'h4000_0000_0000_0000}); #1;
        check("t1_issued_once", 256'(fpu_valid_o), 256'(1'b0));
        check("t1_fpu_ready", 256'(fpu_ready_o), 256'(1'b1));
        @(negedge clk); fpu_valid_i = 1'b0; #1;
        expect_wb("t1_wb");
        check("t1_fflags", 256'(fflags_o), 256'(5'b00001));
        @(negedge clk); #1;
        check("t1_idle", 256'(busy_o), 256'(1'b0));

        // slot exhaustion
        @(negedge clk); push_req(mk_req(MUL, 64'h11), 5'd1); #1;
        @(negedge clk); push_req(mk_req(MUL, 64'h12), 5'd2); #1;
        check("t2_tag0", 256'(fpu_tag_o), 256'(1'b0));
        @(negedge clk); push_req(mk_req(MUL, 64'h14), 5'd4); #1;
        check("t2_tag1", 256'(fpu_tag_o), 256'(1'b1));
        check("t2_valid1", 256'(fpu_valid_o), 256'(1'b1));
        @(negedge clk); req_valid_i = 1'b0; #1;
        check("t2_no_slot", 256'(fpu_valid_o), 256'(1'b0));
        @(negedge clk); give_result(1'b1, 64'hD2, 5'd0); sb.push_back({5'd2, 64'hD2}); #1;
        check("t2_still_stalled", 256'(fpu_valid_o), 256'(1'b0));
        @(negedge clk); fpu_valid_i = 1'b0; #1;
        check("t2_reissue_valid", 256'(fpu_valid_o), 256'(1'b1));
        check("t2_reissue_tag", 256'(fpu_tag_o), 256'(1'b1));
        check("t2_reissue_req", 256'(fpu_req_o), 256'(mk_req(MUL, 64'h14)));
        expect_wb("t2_wb_rd2");
        @(negedge clk); give_result(1'b0, 64'hD1, 5'd0); sb.push_back({5'd1, 64'hD1}); #1;
        @(negedge clk); give_result(1'b1, 64'hD4, 5'd0); sb.push_back({5'd4, 64'hD4}); #1;
        expect_wb("t2_wb_rd1");
        @(negedge clk); fpu_valid_i = 1'b0; #1;
        expect_wb("t2_wb_rd4");
        @(negedge clk); #1;
        check("t2_idle", 256'(busy_o), 256'(1'b0));

        // WAW stall
        @(negedge clk); push_req(mk_req(ADD, 64'h51), 5'd5); #1;
        @(negedge clk); push_req(mk_req(ADD, 64'h52), 5'd5); #1;
        check("t3_first_tag", 256'(fpu_tag_o), 256'(1'b0));
        @(negedge clk); req_valid_i = 1'b0; #1;
        check("t3_waw_stall", 256'(fpu_valid_o), 256'(1'b0));
        @(negedge clk); give_result(1'b0, 64'hD5A, 5'd0); sb.push_back({5'd5, 64'hD5A}); #1;
        check("t3_waw_stall2", 256'(fpu_valid_o), 256'(1'b0));
        @(negedge clk); fpu_valid_i = 1'b0; #1;
        check("t3_waw_release", 256'(fpu_valid_o), 256'(1'b1));
        check("t3_waw_tag", 256'(fpu_tag_o), 256'(1'b0));
        expect_wb("t3_wb_a");
        @(negedge clk); give_result(1'b0, 64'hD5B, 5'd0); sb.push_back({5'd5, 64'hD5B}); #1;
        @(negedge clk); fpu_valid_i = 1'b0; #1;
        expect_wb("t3_wb_b");

        // tag/request stability under FPU back-pressure
        @(negedge clk); push_req(mk_req(DIV, 64'h66), 5'd6); #1;
        @(negedge clk); push_req(mk_req(SQRT, 64'h88), 5'd8); #1;
        check("t3s_tag0", 256'(fpu_tag_o), 256'(1'b0));
        @(negedge clk); req_valid_i = 1'b0; fpu_ready_i = 1'b0; #1;
        check("t3s_offer_tag", 256'(fpu_tag_o), 256'(1'b1));
        @(negedge clk); give_result(1'b0, 64'hD6, 5'd0); sb.push_back({5'd6, 64'hD6}); #1;
        @(negedge clk); fpu_valid_i = 1'b0; fpu_ready_i = 1'b1; #1;
        check("t3s_lock_valid", 256'(fpu_valid_o), 256'(1'b1));
        check("t3s_lock_tag", 256'(fpu_tag_o), 256'(1'b1));
        check("t3s_lock_req", 256'(fpu_req_o), 256'(mk_req(SQRT, 64'h88)));
        expect_wb("t3s_wb6");
        @(negedge clk); give_result(1'b1, 64'hD8, 5'd0); sb.push_back({5'd8, 64'hD8}); #1;
        check("t3s_issued", 256'(fpu_valid_o), 256'(1'b0));
        @(negedge clk); fpu_valid_i = 1'b0; #1;
        expect_wb("t3s_wb8");

        // fflags clear together with an OF result, then NV with wb back-pressure
        @(negedge clk); push_req(mk_req(ADD, 64'hD), 5'd13); #1;
        @(negedge clk); req_valid_i = 1'b0; #1;
        @(negedge clk); give_result(1'b0, 64'hD13, 5'b00100); fflags_clr_i = 1'b1;
        sb.push_back({5'd13, 64'hD13}); #1;
        @(negedge clk); fpu_valid_i = 1'b0; fflags_clr_i = 1'b0; #1;
        expect_wb("t5_wb13");
        check("t5_fflags_of", 256'(fflags_o), 256'(5'b00100));
        @(negedge clk); fflags_clr_i = 1'b1; #1;
        @(negedge clk); fflags_clr_i = 1'b0; push_req(mk_req(ADD, 64'hE), 5'd14); #1;
        check("t5_fflags_clr", 256'(fflags_o), 256'(5'd0));
        @(negedge clk); req_valid_i = 1'b0; #1;
        @(negedge clk); give_result(1'b0, 64'hD14, 5'b10000); wb_ready_i = 1'b0;
        sb.push_back({5'd14, 64'hD14}); #1;
        @(negedge clk); fpu_valid_i = 1'b0; #1;
        check("t4_bp_ready", 256'(fpu_ready_o), 256'(1'b0));
        check("t4_bp_fflags_nv", 256'(fflags_o), 256'(5'b10000));
        @(negedge clk); #1;
        check("t4_bp_hold_valid", 256'(wb_valid_o), 256'(1'b1));
        check("t4_bp_hold_data", 256'(wb_data_o), 256'(64'hD14));
        @(negedge clk); wb_ready_i = 1'b1; #1;
        expect_wb("t4_wb14");
        check("t4_ready_back", 256'(fpu_ready_o), 256'(1'b1));

        // queue full with FPU back-pressure, then flush
        @(negedge clk); fpu_ready_i = 1'b0; push_req(mk_req(ADD, 64'h9), 5'd9); #1;
        @(negedge clk); push_req(mk_req(ADD, 64'hA), 5'd10); #1;
        @(negedge clk); push_req(mk_req(ADD, 64'hB), 5'd11); #1;
        @(negedge clk); push_req(mk_req(ADD, 64'hC), 5'd12); #1;
        check("t4_ready_before_4th", 256'(req_ready_o), 256'(1'b1));
        @(negedge clk); req_valid_i = 1'b0; fpu_ready_i = 1'b1; #1;
        check("t4_full", 256'(req_ready_o), 256'(1'b0));
        check("t4_head_req", 256'(fpu_req_o), 256'(mk_req(ADD, 64'h9)));
        @(negedge clk); push_req(mk_req(ADD, 64'hF), 5'd15); #1;
        check("t4_second_tag", 256'(fpu_tag_o), 256'(1'b1));
        @(negedge clk); push_req(mk_req(ADD, 64'h10), 5'd16); flush_i = 1'b1;
        give_result(1'b0, 64'hBAD0, 5'b00001); #1;
        check("t6_flush_o", 256'(fpu_flush_o), 256'(1'b1));
        check("t6_flush_no_push", 256'(req_ready_o), 256'(1'b0));
        check("t6_flush_no_issue", 256'(fpu_valid_o), 256'(1'b0));
        @(negedge clk); flush_i = 1'b0; req_valid_i = 1'b0;
        give_result(1'b1, 64'hBAD1, 5'b00001); #1;
        check("t6_busy", 256'(busy_o), 256'(1'b0));
        check("t6_fflags_kept", 256'(fflags_o), 256'(5'b10000));
        check("t6_wb_dropped", 256'(wb_valid_o), 256'(1'b0));
        check("t6_flush_low", 256'(fpu_flush_o), 256'(1'b0));
        @(negedge clk); fpu_valid_i = 1'b0; push_req(mk_req(MUL, 64'h20), 5'd20); #1;
        check("t6_stale_no_wb", 256'(wb_valid_o), 256'(1'b0));
        check("t6_stale_fflags", 256'(fflags_o), 256'(5'b10000));
        @(negedge clk); req_valid_i = 1'b0; #1;
        check("t6_post_issue_tag", 256'(fpu_tag_o), 256'(1'b0));
        check("t6_post_issue_req", 256'(fpu_req_o), 256'(mk_req(MUL, 64'h20)));
        @(negedge clk); give_result(1'b0, 64'hD20, 5'd0); sb.push_back({5'd20, 64'hD20}); #1;
        @(negedge clk); fpu_valid_i = 1'b0; #1;
        expect_wb("t6_wb20");
        @(negedge clk); #1;
        check("end_idle", 256'(busy_o), 256'(1'b0));
        check("sb_drained", 256'(sb.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
